// File: rtl/spi_arbiter.sv
// Shares one spi_controller between the core MMIO byte path and the CRAS word spill/fill path.
// CRAS words become 4-byte SPI RAM command + 4 data bytes, LSB first.
module spi_arbiter #(
  parameter logic [7:0]  READ_CMD  = 8'h03,
  parameter logic [7:0]  WRITE_CMD = 8'h02,
  parameter int unsigned IDLE_CYC  = 2
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        m_spi_wr,
  input  logic        m_spi_rd,
  input  logic [7:0]  m_spi_din,
  input  logic        m_spi_ignore_response,
  output logic [7:0]  m_spi_dout,
  output logic        m_data_avail,
  output logic        m_buffer_empty,
  output logic        m_buffer_full,
  output logic        m_blocked,
  input  logic        ras_rd,
  input  logic        ras_wr,
  input  logic [31:0] ras_addr,
  input  logic [31:0] ras_din,
  output logic [31:0] ras_dout,
  output logic        ras_rdy,
  output logic        spi_wr,
  output logic        spi_rd,
  output logic [7:0]  spi_din,
  output logic        spi_ignore_response,
  input  logic [7:0]  spi_dout,
  input  logic        spi_data_avail,
  input  logic        spi_buffer_empty,
  input  logic        spi_buffer_full,
  output logic        ras_busy
);

  localparam int unsigned IdleW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StCore, StCmd, StData, StDrain, StDone} state_e;

  state_e           r_state;
  logic [2:0]       r_cnt;
  logic [IdleW-1:0] r_idle;
  logic [23:0]      r_addr;
  logic [31:0]      r_din;
  logic             r_is_wr;
  logic [23:0]      r_rbuf;
  logic [31:0]      r_ras_dout;

  logic       w_core_stb, w_ras_req, w_spi_quiet, w_grant, w_core_own;
  logic       w_push, w_pop, w_last;
  logic [7:0] w_tx_byte;
  logic       w_unused_addr;

  assign w_unused_addr = ^ras_addr[31:24];  // SPI RAM uses 24-bit addressing

  assign w_core_stb  = m_spi_wr | m_spi_rd;
  assign w_ras_req   = ras_rd | ras_wr;
  assign w_spi_quiet = spi_buffer_empty & ~spi_data_avail;
  assign w_grant     = (r_state == StIdle) & w_ras_req & w_spi_quiet;
  assign w_core_own  = ((r_state == StIdle) & ~w_grant) | (r_state == StCore);
  assign w_push      = ((r_state == StCmd) | (r_state == StData)) & ~spi_buffer_full & ~Rst;
  assign w_pop       = (r_state == StDrain) & ~r_is_wr & spi_data_avail & ~Rst;
  assign w_last      = (r_cnt == 3'd3);

  assign m_spi_dout = spi_dout;
  assign ras_dout   = r_ras_dout;
  assign ras_rdy    = ~Rst & (r_state == StDone);
  assign ras_busy   = ~Rst & ~((r_state == StIdle) | (r_state == StCore));

  always_comb begin
    w_tx_byte = 8'h00;
    if (r_state == StCmd) begin
      case (r_cnt)
        3'd0:    w_tx_byte = r_is_wr ? WRITE_CMD : READ_CMD;
        3'd1:    w_tx_byte = r_addr[23:16];
        3'd2:    w_tx_byte = r_addr[15:8];
        default: w_tx_byte = r_addr[7:0];
      endcase
    end else if ((r_state == StData) && r_is_wr) begin
      case (r_cnt)
        3'd0:    w_tx_byte = r_din[7:0];
        3'd1:    w_tx_byte = r_din[15:8];
        3'd2:    w_tx_byte = r_din[23:16];
        default: w_tx_byte = r_din[31:24];
      endcase
    end
  end

  always_comb begin
    spi_wr              = 1'b0;
    spi_rd              = 1'b0;
    spi_din             = 8'h00;
    spi_ignore_response = 1'b1;
    m_buffer_full       = 1'b1;
    m_buffer_empty      = 1'b0;
    m_data_avail        = 1'b0;
    m_blocked           = 1'b0;
    if (w_core_own) begin
      spi_wr              = m_spi_wr & ~Rst;
      spi_rd              = m_spi_rd & ~Rst;
      spi_din             = m_spi_din;
      spi_ignore_response = m_spi_ignore_response;
      m_buffer_full       = spi_buffer_full;
      m_buffer_empty      = spi_buffer_empty;
      m_data_avail        = spi_data_avail;
    end else begin
      spi_wr              = w_push;
      spi_rd              = w_pop;
      spi_din             = w_tx_byte;
      spi_ignore_response = ~((r_state == StData) & ~r_is_wr);
      m_blocked           = w_core_stb & ~Rst;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= StIdle;
      r_cnt      <= 3'd0;
      r_idle     <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_is_wr    <= 1'b0;
      r_rbuf     <= '0;
      r_ras_dout <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_state <= StCmd;
            r_addr  <= ras_addr[23:0];
            r_din   <= ras_din;
            r_is_wr <= ras_wr;
            r_cnt   <= 3'd0;
          end else if (w_core_stb) begin
            r_state <= StCore;
            r_idle  <= '0;
          end
        end
        StCore: begin
          // Ownership returns only after the controller has been quiet for IDLE_CYC cycles
          if (w_core_stb || !w_spi_quiet) begin
            r_idle <= '0;
          end else if (r_idle == IdleW'(IDLE_CYC - 1)) begin
            r_idle  <= '0;
            r_state <= StIdle;
          end else begin
            r_idle <= r_idle + IdleW'(1);
          end
        end
        StCmd, StData: begin
          if (w_push) begin
            if (w_last) begin
              r_cnt   <= 3'd0;
              r_state <= (r_state == StCmd) ? StData : StDrain;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        StDrain: begin
          if (r_is_wr) begin
            if (spi_buffer_empty) r_state <= StDone;
          end else if (w_pop) begin
            r_rbuf <= {spi_dout, r_rbuf[23:8]};
            if (w_last) begin
              r_cnt      <= 3'd0;
              r_ras_dout <= {spi_dout, r_rbuf};
              r_state    <= StDone;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: behavioural spi_controller model, push/response scoreboards,
// directed scenarios for write, read, collision, core hand-over, backpressure and reset.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        Rst;
  logic        m_spi_wr, m_spi_rd, m_spi_ignore_response;
  logic [7:0]  m_spi_din, m_spi_dout;
  logic        m_data_avail, m_buffer_empty, m_buffer_full, m_blocked;
  logic        ras_rd, ras_wr, ras_rdy, ras_busy;
  logic [31:0] ras_addr, ras_din, ras_dout;
  logic        spi_wr, spi_rd, spi_ignore_response;
  logic [7:0]  spi_din, spi_dout;
  logic        spi_data_avail, spi_buffer_empty, spi_buffer_full;

  always #5 clk = ~clk;

  spi_arbiter dut (
    .clk(clk), .Rst(Rst),
    .m_spi_wr(m_spi_wr), .m_spi_rd(m_spi_rd), .m_spi_din(m_spi_din),
    .m_spi_ignore_response(m_spi_ignore_response), .m_spi_dout(m_spi_dout),
    .m_data_avail(m_data_avail), .m_buffer_empty(m_buffer_empty),
    .m_buffer_full(m_buffer_full), .m_blocked(m_blocked),
    .ras_rd(ras_rd), .ras_wr(ras_wr), .ras_addr(ras_addr), .ras_din(ras_din),
    .ras_dout(ras_dout), .ras_rdy(ras_rdy),
    .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_din(spi_din),
    .spi_ignore_response(spi_ignore_response), .spi_dout(spi_dout),
    .spi_data_avail(spi_data_avail), .spi_buffer_empty(spi_buffer_empty),
    .spi_buffer_full(spi_buffer_full), .ras_busy(ras_busy)
  );

  int n_tests = 0, n_fail = 0;
  int n_push = 0, n_rdy = 0, n_blk = 0;

  // spi_controller model: 4-deep tx queue, one byte shifted every 3 cycles
  logic [8:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  resp_q[$];
  logic [8:0]  exp_q[$];
  logic [31:0] exp_dout_q[$];
  int          tx_n = 0, rx_n = 0, sh = 0;
  logic [7:0]  rx_front = 8'h00;
  logic        force_full = 1'b0;

  assign spi_buffer_empty = (tx_n == 0);
  assign spi_buffer_full  = force_full || (tx_n >= 4);
  assign spi_data_avail   = (rx_n > 0);
  assign spi_dout         = rx_front;

  logic       s_wr, s_rd, s_ign, s_full;
  logic [7:0] s_din;
  logic [8:0] e, t;
  logic [31:0] ed;

  always begin
    @(negedge clk);
    #4;
    s_wr = spi_wr; s_rd = spi_rd; s_din = spi_din; s_ign = spi_ignore_response;
    s_full = spi_buffer_full;
    if (s_wr === 1'b1) begin
      n_push++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: got ign=%b din=%h, required no push", s_ign, s_din);
      end else begin
        e = exp_q.pop_front();
        if ({s_ign, s_din} !== e) begin
          n_fail++;
          $display("FAIL push_byte: got ign=%b din=%h, required ign=%b din=%h",
                   s_ign, s_din, e[8], e[7:0]);
        end
      end
      n_tests++;
      if (s_full !== 1'b0) begin
        n_fail++;
        $display("FAIL push_while_full: got full=%b at push, required 0", s_full);
      end
    end
    if (m_blocked === 1'b1) n_blk++;
    if (ras_rdy === 1'b1) begin
      n_rdy++;
      if (exp_dout_q.size() > 0) begin
        ed = exp_dout_q.pop_front();
        n_tests++;
        if (ras_dout !== ed) begin
          n_fail++;
          $display("FAIL ras_dout: got %h, required %h", ras_dout, ed);
        end
      end
    end
    @(posedge clk);
    #1;
    if (s_wr === 1'b1) tx_q.push_back({s_ign, s_din});
    if (s_rd === 1'b1 && rx_q.size() > 0) void'(rx_q.pop_front());
    if (tx_q.size() > 0) begin
      sh++;
      if (sh == 3) begin
        sh = 0;
        t = tx_q.pop_front();
        if (!t[8]) begin
          if (resp_q.size() > 0) rx_q.push_back(resp_q.pop_front());
          else rx_q.push_back(8'hA5);
        end
      end
    end
    tx_n = tx_q.size();
    rx_n = rx_q.size();
    rx_front = (rx_n > 0) ? rx_q[0] : 8'h00;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cras_start(input bit wr, input logic [31:0] addr, input logic [31:0] din);
    exp_q.push_back({1'b1, wr ? 8'h02 : 8'h03});
    exp_q.push_back({1'b1, addr[23:16]});
    exp_q.push_back({1'b1, addr[15:8]});
    exp_q.push_back({1'b1, addr[7:0]});
    for (int i = 0; i < 4; i++) exp_q.push_back(wr ? {1'b1, din[8*i +: 8]} : 9'h000);
    ras_addr = addr; ras_din = din; ras_wr = wr; ras_rd = !wr;
  endtask

  task automatic cras_finish(input string name, input int budget, output logic emp);
    bit got = 0;
    emp = 1'bx;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (ras_rdy === 1'b1) begin
        got = 1;
        emp = spi_buffer_empty;
      end
    end
    ras_wr = 0; ras_rd = 0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_rdy: got no ras_rdy in %0d cycles, required one", name, budget);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    Rst = 1; m_spi_wr = 0; m_spi_rd = 0; m_spi_din = 0; m_spi_ignore_response = 1;
    ras_rd = 0; ras_wr = 0; ras_addr = 0; ras_din = 0;
    repeat (2) @(negedge clk);
    m_spi_wr = 1;
    #1;
    check_bit("rst_spi_wr", spi_wr, 1'b0);
    check_bit("rst_blocked", m_blocked, 1'b0);
    @(negedge clk);
    m_spi_wr = 0; Rst = 0;
    #1;
    check_bit("rst_busy", ras_busy, 1'b0);
    check_bit("rst_rdy", ras_rdy, 1'b0);
    n_tests++;
    if (ras_dout !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_dout: got %h, required 00000000", ras_dout);
    end
    check_bit("rst_m_empty", m_buffer_empty, 1'b1);
    check_bit("rst_m_full", m_buffer_full, 1'b0);
    check_bit("rst_m_avail", m_data_avail, 1'b0);
  endtask

  task automatic test_write();
    int r0, b0;
    logic emp;
    @(negedge clk);
    r0 = n_rdy; b0 = n_blk;
    cras_start(1'b1, 32'h0001_2345, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    m_spi_wr = 1; m_spi_din = 8'hFF;
    #1;
    check_bit("wr_blocked", m_blocked, 1'b1);
    check_bit("wr_m_full", m_buffer_full, 1'b1);
    check_bit("wr_m_empty", m_buffer_empty, 1'b0);
    @(negedge clk);
    m_spi_wr = 0;
    cras_finish("wr", 300, emp);
    check_bit("wr_empty_at_rdy", emp, 1'b1);
    repeat (4) @(negedge clk);
    check_int("wr_rdy_count", n_rdy - r0, 1);
    check_int("wr_bytes_left", exp_q.size(), 0);
    check_int("wr_blk_count", n_blk - b0, 1);
  endtask

  task automatic test_read();
    int r0;
    logic emp;
    @(negedge clk);
    r0 = n_rdy;
    resp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_dout_q.push_back(32'h4433_2211);
    cras_start(1'b0, 32'h0000_0010, 32'h0);
    cras_finish("rd", 300, emp);
    repeat (5) @(negedge clk);
    n_tests++;
    if (ras_dout !== 32'h4433_2211) begin
      n_fail++;
      $display("FAIL rd_dout_hold: got %h, required 44332211", ras_dout);
    end
    check_int("rd_rdy_count", n_rdy - r0, 1);
    check_int("rd_bytes_left", exp_q.size(), 0);
  endtask

  task automatic test_collision();
    int b0;
    logic emp;
    @(negedge clk);
    b0 = n_blk;
    cras_start(1'b1, 32'h00AB_CDEF, 32'h0102_0304);
    m_spi_wr = 1; m_spi_din = 8'h77;
    #1;
    check_bit("col_blocked", m_blocked, 1'b1);
    check_bit("col_spi_wr", spi_wr, 1'b0);
    @(negedge clk);
    m_spi_wr = 0;
    #1;
    check_bit("col_busy", ras_busy, 1'b1);
    check_bit("col_blocked_off", m_blocked, 1'b0);
    cras_finish("col", 300, emp);
    repeat (3) @(negedge clk);
    check_int("col_blk_count", n_blk - b0, 1);
    check_int("col_bytes_left", exp_q.size(), 0);
  endtask

  task automatic test_core_then_cras();
    bit got = 0;
    int q = 0;
    logic emp;
    @(negedge clk);
    m_spi_wr = 1; m_spi_din = 8'h5A; m_spi_ignore_response = 0;
    exp_q.push_back({1'b0, 8'h5A});
    resp_q.push_back(8'h9C);
    #1;
    check_bit("core_passthru_wr", spi_wr, 1'b1);
    @(negedge clk);
    m_spi_wr = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (m_data_avail === 1'b1) got = 1;
    end
    check_bit("core_avail", got, 1'b1);
    n_tests++;
    if (m_spi_dout !== 8'h9C) begin
      n_fail++;
      $display("FAIL core_dout: got %h, required 9c", m_spi_dout);
    end
    m_spi_rd = 1;
    #1;
    check_bit("core_passthru_rd", spi_rd, 1'b1);
    @(negedge clk);
    m_spi_rd = 0; m_spi_wr = 1; m_spi_din = 8'hA6; m_spi_ignore_response = 1;
    exp_q.push_back({1'b1, 8'hA6});
    resp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_dout_q.push_back(32'h0403_0201);
    cras_start(1'b0, 32'h0055_6677, 32'h0);
    @(negedge clk);
    m_spi_wr = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (ras_busy === 1'b1) got = 1;
      else begin
        if (spi_buffer_empty && !spi_data_avail) q++;
        else q = 0;
        @(negedge clk);
      end
    end
    check_bit("handover_busy", got, 1'b1);
    check_int("handover_quiet_cycles", q, 3);
    check_bit("busy_m_full", m_buffer_full, 1'b1);
    check_bit("busy_m_avail", m_data_avail, 1'b0);
    cras_finish("handover", 300, emp);
    repeat (3) @(negedge clk);
    check_int("handover_bytes_left", exp_q.size(), 0);
  endtask

  task automatic test_backpressure();
    bit got = 0;
    int p0;
    logic emp;
    @(negedge clk);
    cras_start(1'b1, 32'h0000_0ABC, 32'h89AB_CDEF);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (exp_q.size() <= 3) got = 1;
    end
    check_bit("bp_reach_data", got, 1'b1);
    force_full = 1;
    p0 = n_push;
    repeat (5) @(negedge clk);
    force_full = 0;
    check_int("bp_no_push_when_full", n_push - p0, 0);
    cras_finish("bp", 300, emp);
    repeat (3) @(negedge clk);
    check_int("bp_bytes_left", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    int p0, r0;
    @(negedge clk);
    r0 = n_rdy;
    p0 = n_push;
    cras_start(1'b1, 32'h0012_3456, 32'h1122_3344);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (n_push - p0 >= 3) got = 1;
    end
    check_bit("rstmid_reach", got, 1'b1);
    Rst = 1;
    #1;
    check_bit("rstmid_spi_wr", spi_wr, 1'b0);
    @(negedge clk);
    Rst = 0; ras_wr = 0;
    #1;
    check_bit("rstmid_busy", ras_busy, 1'b0);
    exp_q.delete();
    p0 = n_push;
    repeat (20) @(negedge clk);
    check_int("rstmid_no_push", n_push - p0, 0);
    check_int("rstmid_no_rdy", n_rdy - r0, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_collision();
    test_core_then_cras();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameters (name, default, meaning): READ_CMD, 8'h03, SPI RAM read opcode; WRITE_CMD, 8'h02, SPI RAM write opcode; IDLE_CYC, 2, consecutive idle cycles before the core releases ownership.
REQ-002 Ports (name, direction, width, meaning), listed below.
- clk, in, 1, single clock; all logic is on posedge clk.
- Rst, in, 1, reset; synchronous, active-high.
- m_spi_wr / m_spi_rd, in, 1 each, core MMIO byte push / byte pop strobes.
- m_spi_din, in, 8, core transmit byte.
- m_spi_ignore_response, in, 1, core ignore-response flag.
- m_spi_dout, out, 8, response byte to the core.
- m_data_avail / m_buffer_empty / m_buffer_full, out, 1 each, status as seen by the core.
- m_blocked, out, 1, one-cycle pulse when a core strobe is dropped.
- ras_rd / ras_wr, in, 1 each, CRAS word read/write request, held until ras_rdy.
- ras_addr / ras_din, in, 32 each, CRAS word address / write data.
- ras_dout, out, 32, read word.
- ras_rdy, out, 1, one-cycle completion pulse.
- spi_wr / spi_rd, out, 1 each, push / pop strobes to spi_controller.
- spi_din, out, 8, transmit byte.
- spi_ignore_response, out, 1, ignore-response flag.
- spi_dout, in, 8, response byte; valid while spi_data_avail.
- spi_data_avail / spi_buffer_empty / spi_buffer_full, in, 1 each, spi_controller status.
- ras_busy, out, 1, high in CMD, DATA, DRAIN and DONE.

Function
REQ-003 The block shall share one spi_controller between the core MMIO path and the CRAS spill/fill path, granting exactly one owner at a time.
REQ-004 States shall be IDLE, CORE, CMD, DATA, DRAIN and DONE.
REQ-005 IDLE with (ras_rd|ras_wr), spi_buffer_empty=1 and spi_data_avail=0 shall go to CMD.
- It shall latch ras_addr, ras_din and op (ras_wr wins if both are high).
- CRAS shall win over a same-cycle core strobe; that core strobe shall be dropped and m_blocked pulsed.
REQ-006 IDLE with a core strobe and no eligible CRAS request shall pass the strobe through in that same cycle and go to CORE.
REQ-007 In IDLE/CORE, spi_wr, spi_rd, spi_din and spi_ignore_response shall equal the core inputs combinationally.
- m_data_avail=spi_data_avail, m_spi_dout=spi_dout, m_buffer_full=spi_buffer_full, m_buffer_empty=spi_buffer_empty.
REQ-008 CORE shall return to IDLE after IDLE_CYC consecutive cycles with spi_buffer_empty=1, spi_data_avail=0 and no core strobe.
- Any strobe shall clear the idle counter.
- A pending CRAS request shall not preempt CORE.
REQ-009 Outside IDLE/CORE, outputs to the core shall read m_buffer_full=1, m_buffer_empty=0, m_data_avail=0.
- Core strobes shall not reach spi_controller; each dropped strobe cycle shall pulse m_blocked.
REQ-010 CMD shall push 4 bytes with spi_ignore_response=1: opcode, then addr[23:16], addr[15:8], addr[7:0].
REQ-011 DATA shall push 4 bytes, least significant first.
- Write: data bytes with spi_ignore_response=1.
- Read: 8'h00 dummy bytes with spi_ignore_response=0.
REQ-012 Each push shall be a single-cycle spi_wr issued only in a cycle with spi_buffer_full=0.
- A 3-bit byte counter shall advance only on a push and wrap 3->0 on the CMD->DATA and DATA->DRAIN transitions.
REQ-013 DRAIN, read:
- On each cycle with spi_data_avail=1, pulse spi_rd and shift spi_dout into ras_dout[8k+7:8k], k=0..3 in arrival order.
- After the 4th byte, go to DONE.
REQ-014 DRAIN, write: go to DONE on the first cycle with spi_buffer_empty=1.
REQ-015 DONE shall pulse ras_rdy for exactly one cycle and return to IDLE.
- ras_dout shall hold its value until the next read completes.
- A request still high in the following IDLE cycle shall be treated as a new transaction.
REQ-016 Dropping ras_rd/ras_wr mid-transaction shall not abort it; ras_rdy still pulses.
REQ-017 Transaction latency shall have no timeout; backpressure from spi_buffer_full shall stall without losing bytes.

Reset
REQ-018 A cycle with Rst=1 shall force IDLE and clear the counters.
- Outputs: ras_dout=0, ras_rdy=0, ras_busy=0, m_blocked=0, spi_wr=0, spi_rd=0.
- Core status outputs then track REQ-007.
REQ-019 Rst mid-transaction shall abandon the transaction with no ras_rdy.
- No further spi_wr/spi_rd shall be issued until a new request.

Verification
REQ-020 The bench shall cover the following directed scenarios.
- V1: Write, ras_addr=32'h0001_2345, ras_din=32'hDEAD_BEEF -> spi_din sequence 02,01,23,45,EF,BE,AD,DE, all with ignore=1; one ras_rdy after empty.
- V2: Read, ras_addr=32'h0000_0010, model returns 11,22,33,44 -> bytes 03,00,00,10 (ignore=1), 00x4 (ignore=0); ras_dout=32'h4433_2211; one ras_rdy.
- V3: ras_wr and m_spi_wr in the same IDLE cycle -> CRAS granted; m_blocked=1 for one cycle; core byte not pushed.
- V4: Core owns with traffic, then raises ras_rd -> CRAS starts only after 2 idle cycles with spi_buffer_empty=1.
- V5: spi_buffer_full=1 for 5 cycles during DATA -> no spi_wr in those cycles; all 8 bytes still sent, in order.
- V6: Rst asserted after 3 CMD bytes -> next cycle IDLE, ras_busy=0; no ras_rdy; no further pushes.
